fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, fetched-instruction buffer entries (legal 2..8, power of 2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  level; fetching allowed while high.
REQ-006 imem_req  output  1  one-cycle fetch request pulse to instruction memory.
REQ-007 imem_addr  output  32  fetch address, word aligned, valid when imem_req=1.
REQ-008 imem_rvalid  input  1  response strobe, arrives 1..N cycles after imem_req.
REQ-009 imem_rdata  input  32  fetched instruction word, valid with imem_rvalid.
REQ-010 redirect_valid  input  1  branch/jump redirect strobe.
REQ-011 redirect_pc  input  32  redirect target; bits [1:0] ignored (treated as 0).
REQ-012 instr_valid  output  1  buffer head valid.
REQ-013 instr_ready  input  1  consumer accepts head when instr_valid=1.
REQ-014 instr_data  output  32  head instruction word.
REQ-015 instr_pc  output  32  address of head instruction.
REQ-016 instr_illegal  output  1  head opcode unsupported (see Configuration).

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, FLUSH; at most one request outstanding.
REQ-018 IDLE: start=1 -> ISSUE; otherwise stay; no requests issued.
REQ-019 ISSUE: if buffer has a free slot (count < BUF_DEPTH, counting a same-cycle pop), assert imem_req with imem_addr=fetch_pc, go WAIT; else hold in ISSUE, imem_req=0.
REQ-020 ISSUE with start=0 -> IDLE without request.
REQ-021 WAIT: on imem_rvalid push {fetch_pc, imem_rdata}, fetch_pc += 4 (mod 2^32 wrap), go ISSUE.
REQ-022 Push-to-visible latency: data accepted on imem_rvalid edge appears on instr_* the following cycle when buffer was empty.
REQ-023 Pop occurs when instr_valid & instr_ready; simultaneous push and pop on a full buffer is legal, count unchanged.
REQ-024 Redirect in IDLE/ISSUE: buffer cleared, fetch_pc=redirect_pc&~3, next request no earlier than the following cycle.
REQ-025 Redirect in WAIT without same-cycle imem_rvalid: buffer cleared, fetch_pc updated, go FLUSH.
REQ-026 Redirect in WAIT with same-cycle imem_rvalid: response discarded, buffer cleared, fetch_pc updated, go ISSUE.
REQ-027 FLUSH: discard next imem_rvalid, then go ISSUE; a further redirect in FLUSH updates fetch_pc, stays FLUSH.
REQ-028 Redirect has priority over pop and push in the same cycle; instr_valid=0 the cycle after a redirect.
REQ-029 imem_rvalid outside WAIT/FLUSH ignored.
REQ-030 instr_data/instr_pc hold stable while instr_valid=1 and instr_ready=0.

Reset
REQ-031 rst_n low: state=IDLE, fetch_pc=RESET_PC, buffer empty, imem_req=0, instr_valid=0, instr_data=0, instr_pc=0, instr_illegal=0.
REQ-032 Reset mid-WAIT: pending response after release is ignored (state IDLE).

Configuration
REQ-033 Macro FETCH_ILLEGAL_OPCODE_EN defined: instr_illegal=1 when head opcode[6:0] not in {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111}; flag stored per entry at push.
REQ-034 Macro undefined: instr_illegal tied 0, no opcode logic or storage.

Structure
REQ-035 Shared package riscv_pkg: FSM state enum, opcode constants, RESET_PC default.
REQ-036 One sub-module fetch_buffer: synchronous FIFO (push, pop, clear, count, head) of width 32+32(+1).

Verification
REQ-039 Reset then start=1, 1-cycle memory latency, instr_ready=1: addresses 0x0,0x4,0x8 issued; instr_pc sequence 0x0,0x4,0x8.
REQ-040 instr_ready=0, BUF_DEPTH=2: exactly 2 responses buffered, ISSUE holds with imem_req=0; one pop -> one new request at 0x8.
REQ-041 Redirect to 0x103 during WAIT (latency 3): late response dropped, next imem_addr=0x100, instr_pc=0x100 first.
REQ-042 Redirect coincident with imem_rvalid and pop: buffer empty next cycle, next imem_addr=redirect target.
REQ-043 RESET_PC=0xFFFF_FFFC: second fetch at 0x0000_0000 (wrap).
REQ-044 With FETCH_ILLEGAL_OPCODE_EN, imem_rdata=0x0000_007F -> instr_illegal=1; 0x0020_8033 -> 0; without macro both 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: fetch FSM states, RV32I base opcodes and reset-PC default shared by the fetch slice.
package riscv_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FLUSH} fetch_state_e;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  function automatic logic opcode_illegal(input logic [6:0] op);
    return !(op inside {OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC});
  endfunction
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: synchronous FIFO of fetched entries with push, pop, clear, occupancy and head.
module fetch_buffer #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             data_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_q] <= data_i;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
    end
  end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: single-outstanding instruction fetch FSM feeding a small instruction buffer.
// Define FETCH_ILLEGAL_OPCODE_EN to flag unsupported opcodes per buffered entry.
module fetch_sequencer
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        instr_illegal
);
  localparam int AW = $clog2(BUF_DEPTH);
`ifdef FETCH_ILLEGAL_OPCODE_EN
  localparam int W = 65;
`else
  localparam int W = 64;
`endif
  localparam logic [AW:0] FULL = (AW+1)'(BUF_DEPTH);
  fetch_state_e state_q;
  logic [31:0]  fetch_pc_q;
  logic         req_q;
  logic [AW:0]  cnt;
  logic [W-1:0] head, push_data;
  logic         push, pop, free;
  assign instr_valid = cnt != '0;
  assign pop         = instr_valid & instr_ready & ~redirect_valid;
  assign push        = (state_q == WAIT) & imem_rvalid & ~redirect_valid;
  assign free        = (cnt != FULL) | pop;
  assign imem_req    = req_q;
  assign imem_addr   = fetch_pc_q;
  assign instr_data  = instr_valid ? head[31:0] : '0;
  assign instr_pc    = instr_valid ? head[63:32] : '0;
`ifdef FETCH_ILLEGAL_OPCODE_EN
  assign push_data     = {opcode_illegal(imem_rdata[6:0]), fetch_pc_q, imem_rdata};
  assign instr_illegal = instr_valid & head[64];
`else
  assign push_data     = {fetch_pc_q, imem_rdata};
  assign instr_illegal = 1'b0;
`endif
  fetch_buffer #(.W(W), .DEPTH(BUF_DEPTH)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (redirect_valid),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_data),
    .head_o  (head),
    .count_o (cnt)
  );
  // The request is registered, so it is presented during the first WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
    end else begin
      req_q <= 1'b0;
      if (redirect_valid) fetch_pc_q <= redirect_pc & ~32'h3;
      else if (push) fetch_pc_q <= fetch_pc_q + 32'd4;
      case (state_q)
        IDLE:  state_q <= start ? ISSUE : IDLE;
        ISSUE: begin
          if (!start) state_q <= IDLE;
          else if (!redirect_valid && free) begin
            state_q <= WAIT;
            req_q   <= 1'b1;
          end
        end
        WAIT: begin
          if (redirect_valid) state_q <= imem_rvalid ? ISSUE : FLUSH;
          else if (imem_rvalid) state_q <= ISSUE;
        end
        FLUSH:   if (imem_rvalid) state_q <= ISSUE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
